// File: rtl/top_bus_master_if.sv
// Request/response and shared-bus signals of the register bus initiator.
// Handshake: a request transfers on any cycle where req_valid && req_ready;
// the requester holds its fields stable only for that cycle. rsp_valid is a
// single-cycle pulse with no back-pressure.
interface top_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [7:0] bus_data_in;
  logic       ale;
  logic       write;
  logic       read;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_data_in,
    output req_ready, rsp_valid, rsp_rdata, bus_data_out, bus_data_oe,
           ale, write, read
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_data_in,
    input  req_ready, rsp_valid, rsp_rdata, bus_data_out, bus_data_oe,
           ale, write, read
  );
endinterface

// File: rtl/top_bus_master.sv
// Register bus initiator: turns single read/write requests into timed
// ale / write / read strobe cycles on the shared 8-bit data bus.
module top_bus_master #(
  parameter int T_ALE    = 2,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 1
) (
  input  logic              osc,
  input  logic              rst,
  top_bus_master_if.master  bus,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    IDLE, ADDR, AHOLD, WSETUP, WSTROBE, WHOLD, RTURN, RSTROBE, RHOLD, DONE
  } state_t;

  // Counter reload values; a zero-length phase still lasts one cycle.
  localparam logic [7:0] N_ALE    = (T_ALE    < 1) ? 8'd0 : 8'(T_ALE - 1);
  localparam logic [7:0] N_SETUP  = (T_SETUP  < 1) ? 8'd0 : 8'(T_SETUP - 1);
  localparam logic [7:0] N_STROBE = (T_STROBE < 1) ? 8'd0 : 8'(T_STROBE - 1);
  localparam logic [7:0] N_HOLD   = (T_HOLD   < 1) ? 8'd0 : 8'(T_HOLD - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cur_addr;
  logic [7:0] cur_wdata;
  logic       cur_write;
  logic [7:0] last_addr;
  logic       addr_known;

  assign state_dbg = state;

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      cur_addr         <= 8'd0;
      cur_wdata        <= 8'd0;
      cur_write        <= 1'b0;
      last_addr        <= 8'd0;
      addr_known       <= 1'b0;
      bus.ale          <= 1'b0;
      bus.write        <= 1'b1;
      bus.read         <= 1'b1;
      bus.bus_data_oe  <= 1'b0;
      bus.bus_data_out <= 8'd0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            cur_addr      <= bus.req_addr;
            cur_wdata     <= bus.req_wdata;
            cur_write     <= bus.req_write;
            if (addr_known && bus.req_addr == last_addr) begin
              // Responder already holds this address: go straight to data.
              cnt <= N_SETUP;
              if (bus.req_write) begin
                state            <= WSETUP;
                bus.bus_data_oe  <= 1'b1;
                bus.bus_data_out <= bus.req_wdata;
              end else begin
                state           <= RTURN;
                bus.bus_data_oe <= 1'b0;
              end
            end else begin
              state            <= ADDR;
              cnt              <= N_ALE;
              bus.ale          <= 1'b1;
              bus.bus_data_oe  <= 1'b1;
              bus.bus_data_out <= bus.req_addr;
            end
          end
        end
        ADDR: begin
          if (cnt == 8'd0) begin
            state   <= AHOLD;
            cnt     <= N_HOLD;
            bus.ale <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        AHOLD: begin
          if (cnt == 8'd0) begin
            last_addr  <= cur_addr;
            addr_known <= 1'b1;
            cnt        <= N_SETUP;
            if (cur_write) begin
              state            <= WSETUP;
              bus.bus_data_out <= cur_wdata;
            end else begin
              state           <= RTURN;
              bus.bus_data_oe <= 1'b0;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WSETUP: begin
          if (cnt == 8'd0) begin
            state     <= WSTROBE;
            cnt       <= N_STROBE;
            bus.write <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WSTROBE: begin
          if (cnt == 8'd0) begin
            state     <= WHOLD;
            cnt       <= N_HOLD;
            bus.write <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WHOLD: begin
          if (cnt == 8'd0) begin
            state           <= DONE;
            bus.bus_data_oe <= 1'b0;
            bus.rsp_valid   <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RTURN: begin
          if (cnt == 8'd0) begin
            state    <= RSTROBE;
            cnt      <= N_STROBE;
            bus.read <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RSTROBE: begin
          if (cnt == 8'd0) begin
            // Sample while the responder is still driving, before read rises.
            bus.rsp_rdata <= bus.bus_data_in;
            state         <= RHOLD;
            cnt           <= N_HOLD;
            bus.read      <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RHOLD: begin
          if (cnt == 8'd0) begin
            state         <= DONE;
            bus.rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state           <= IDLE;
          bus.rsp_valid   <= 1'b0;
          bus.req_ready   <= 1'b1;
          bus.bus_data_oe <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          bus.ale         <= 1'b0;
          bus.write       <= 1'b1;
          bus.read        <= 1'b1;
          bus.bus_data_oe <= 1'b0;
          bus.rsp_valid   <= 1'b0;
          bus.req_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_bus_master.sv
// Directed bench for top_bus_master: a table of register accesses with
// hand-computed strobe counts and latencies, plus a reset-abort sequence.
module tb_top_bus_master;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] resp;
    logic       hold;
    int         exp_ale;
    int         exp_oe;
    int         exp_lat;
  } vec_t;

  logic       osc = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] state_dbg;
  logic [7:0] resp_val = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         rule_viol = 0;
  logic       prev_read = 1'b1;
  logic       prev_oe = 1'b0;
  vec_t       vecs[10];
  vec_t       v;

  top_bus_master_if bus();

  top_bus_master dut (
    .osc       (osc),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  always #5 osc = ~osc;

  // Responder: drives the bus only while read is low, junk otherwise.
  assign bus.bus_data_in = bus.read ? 8'hEE : resp_val;

  // Bus-rule monitor
  always @(negedge osc) begin
    if (!rst) begin
      if (!bus.write && !bus.read) rule_viol++;
      if (bus.ale && (!bus.write || !bus.read)) rule_viol++;
      if (bus.bus_data_oe && !bus.read) rule_viol++;
      if (prev_read && !bus.read && prev_oe) rule_viol++;
    end
    prev_read <= bus.read;
    prev_oe   <= bus.bus_data_oe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: issue one request, observe it until rsp_valid, then compare.
  task automatic run_txn(input vec_t t, input string tag);
    int lat, ale_n, strobe_n, oe_n, data_bad, ready_bad, wait_n;
    ale_n = 0; strobe_n = 0; oe_n = 0; data_bad = 0; ready_bad = 0;
    @(negedge osc);
    bus.req_valid = 1'b1;
    bus.req_write = t.wr;
    bus.req_addr  = t.addr;
    bus.req_wdata = t.wdata;
    resp_val      = t.resp;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 40) begin
      @(negedge osc);
      wait_n++;
    end
    check({tag, "_accept_wait"}, wait_n, 0);
    @(negedge osc);
    lat = 2;
    if (t.hold) begin
      bus.req_addr  = t.addr ^ 8'h80;
      bus.req_wdata = ~t.wdata;
      bus.req_write = ~t.wr;
    end else begin
      bus.req_valid = 1'b0;
      bus.req_addr  = 8'hFF;
      bus.req_wdata = 8'h00;
      bus.req_write = ~t.wr;
    end
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.req_ready) ready_bad++;
      if (bus.ale) begin
        ale_n++;
        if (!bus.bus_data_oe || bus.bus_data_out != t.addr) data_bad++;
      end
      if (!bus.write) begin
        strobe_n++;
        if (!bus.bus_data_oe || bus.bus_data_out != t.wdata) data_bad++;
      end
      if (!bus.read) strobe_n++;
      if (bus.bus_data_oe) oe_n++;
      @(negedge osc);
      lat++;
      if (t.hold) begin
        bus.req_addr  = t.addr ^ 8'(lat) ^ 8'h40;
        bus.req_wdata = t.wdata ^ 8'(lat);
      end
    end
    if (bus.req_ready) ready_bad++;
    check({tag, "_latency"}, lat, t.exp_lat);
    check({tag, "_ale_cycles"}, ale_n, t.exp_ale);
    check({tag, "_strobe_cycles"}, strobe_n, 3);
    check({tag, "_oe_cycles"}, oe_n, t.exp_oe);
    check({tag, "_bus_data"}, data_bad, 0);
    check({tag, "_ready_low"}, ready_bad, 0);
    if (!t.wr) check({tag, "_rdata"}, int'(bus.rsp_rdata), int'(t.resp));
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;

    // Stimulus table: {wr, addr, wdata, resp, hold, exp_ale, exp_oe, exp_lat}
    vecs[0] = '{1'b1, 8'h13, 8'h5A, 8'h00, 1'b0, 2, 9, 11};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 2, 3, 11};
    vecs[2] = '{1'b1, 8'h15, 8'h3C, 8'h00, 1'b0, 2, 9, 11};
    vecs[3] = '{1'b0, 8'h15, 8'h00, 8'h77, 1'b0, 0, 0, 8};
    vecs[4] = '{1'b1, 8'h13, 8'h11, 8'h00, 1'b0, 2, 9, 11};
    vecs[5] = '{1'b1, 8'h14, 8'h22, 8'h00, 1'b0, 2, 9, 11};
    vecs[6] = '{1'b0, 8'h14, 8'h00, 8'hC3, 1'b0, 0, 0, 8};
    vecs[7] = '{1'b1, 8'h14, 8'h99, 8'h00, 1'b0, 0, 6, 8};
    vecs[8] = '{1'b1, 8'h30, 8'h44, 8'h00, 1'b1, 2, 9, 11};
    vecs[9] = '{1'b0, 8'h30, 8'h00, 8'h5E, 1'b0, 0, 0, 8};

    #1 rst = 1'b1;
    #10;
    check("rst_ale", int'(bus.ale), 0);
    check("rst_write", int'(bus.write), 1);
    check("rst_read", int'(bus.read), 1);
    check("rst_oe", int'(bus.bus_data_oe), 0);
    check("rst_data_out", int'(bus.bus_data_out), 0);
    check("rst_ready", int'(bus.req_ready), 1);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rdata", int'(bus.rsp_rdata), 0);
    @(negedge osc);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of the write strobe.
    @(negedge osc);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h20;
    bus.req_wdata = 8'h66;
    @(negedge osc);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.write && n < 30) begin
      @(negedge osc);
      n++;
    end
    check("abort_reach_wstrobe", int'(bus.write), 0);
    @(negedge osc);
    #2 rst = 1'b1;
    #1;
    check("abort_write", int'(bus.write), 1);
    check("abort_oe", int'(bus.bus_data_oe), 0);
    check("abort_ale", int'(bus.ale), 0);
    check("abort_read", int'(bus.read), 1);
    check("abort_ready", int'(bus.req_ready), 1);
    @(negedge osc);
    rst = 1'b0;
    n = 0;
    repeat (15) begin
      @(negedge osc);
      if (bus.rsp_valid) n++;
    end
    check("abort_no_rsp", n, 0);

    v = '{1'b1, 8'h20, 8'h66, 8'h00, 1'b0, 2, 9, 11};
    run_txn(v, "post_rst_wr");
    v = '{1'b0, 8'h20, 8'h00, 8'h0F, 1'b0, 0, 0, 8};
    run_txn(v, "post_rst_rd");

    @(negedge osc);
    check("bus_rules", rule_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
